// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl (with leaf full_adder)
//  Description : Bit-serial WIDTH-bit adder. Operands are captured on a
//                valid/ready handshake, then fed LSB-first through one
//                full_adder, one bit per clock, with the carry registered and
//                fed back. The collected sum and final carry are presented on
//                a valid/ready output handshake.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready, a, b, c_in   - operand side
//                out_valid/out_ready, sum, c_out - result side
//                busy                            - high while bits are shifting
//  Revision    : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
// full_adder : single-bit combinational full adder
//   x, y, c_in : addend bits and carry-in
//   s, c_out   : sum bit and carry-out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

// ---------------------------------------------------------------------------
// serial_adder_ctrl : control and datapath around the single full_adder
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               c_out_q,  c_out_d;

    logic               fa_s;
    logic               fa_c_out;

    full_adder u_fa (
        .x     (a_sr_q[0]),
        .y     (b_sr_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) result bit has arrived at position 0.
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_c_out;
                if (cnt_q == CNT_LAST) begin
                    // Counter parks at its last value rather than wrapping.
                    sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                    c_out_d = fa_c_out;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Scoreboard bench for serial_adder_ctrl. The stimulus side
//                pushes the arithmetic result (a+b+c_in) and the accept cycle
//                into a queue; a monitor pops it whenever a result is
//                handed over and compares sum, c_out and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          busy;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_or  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout/unexpected expected=event (t=%0t)", name, $time);
    endtask

    // Advance to just after the next rising edge; optionally randomise out_ready.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference model: plain integer addition.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] full;
        exp_t e;
        full  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.s   = full[W-1:0];
        e.co  = full[W];
        e.acc = 0;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int   t;
        bit   got;
        exp_t e;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        c_in     = cv;
        t        = 0;
        got      = 1'b0;
        while (!got && t < 200) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else begin
                tick();
                t++;
            end
        end
        if (!got) begin
            fail_now("send_accept_timeout");
        end else begin
            e     = model(av, bv, cv);
            e.acc = cyc + 1;
            sb.push_back(e);
            tick();
        end
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        c_in     = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || !in_ready) && t < 400) begin
            tick();
            t++;
        end
        if (t >= 400) fail_now("drain_timeout");
    endtask

    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb.size() == 0) fail_now("unexpected_out_valid");
                    else begin
                        check("latency", 32'(cyc - sb[0].acc), 32'(W));
                        check("busy_in_done", {31'b0, busy}, 32'd0);
                        check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
                    end
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sum", {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, e.s});
                    check("c_out", {31'b0, c_out}, {31'b0, e.co});
                end
                prev = out_valid;
            end
        end
    endtask

    task automatic stimulus();
        int t;
        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #10;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sum", {24'b0, sum}, 32'd0);
        check("rst_c_out", {31'b0, c_out}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // Directed additions
        out_ready = 1'b1;
        send(8'h3C, 8'h05, 1'b0); drain();
        send(8'hFF, 8'h01, 1'b0); drain();
        send(8'hFF, 8'hFF, 1'b1); drain();

        // Back-pressure hold in DONE
        out_ready = 1'b0;
        send(8'h3C, 8'h05, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_now("hold_wait_out_valid");
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_sum", {24'b0, sum}, 32'h41);
            check("hold_c_out", {31'b0, c_out}, 32'd0);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_out_valid", {31'b0, out_valid}, 32'd0);
        tick();

        // in_valid pulse during RUN must be ignored
        send(8'h3C, 8'h05, 1'b0);
        tick(); tick();
        in_valid = 1'b1; a = 8'h11; b = 8'h00; c_in = 1'b0;
        tick();
        in_valid = 1'b0;
        drain();

        // Reset in the middle of RUN
        send(8'hAA, 8'h11, 1'b0);
        tick(); tick(); tick();
        #20;
        rst = 1'b1;
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_sum", {24'b0, sum}, 32'd0);
        sb.delete();
        @(posedge clk); #1; rst = 1'b0;
        tick();
        send(8'h80, 8'h80, 1'b0); drain();

        // Randomised traffic with random back-pressure
        rand_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            case ($urandom_range(0, 5))
                0:       send(8'hFF, W'($urandom), 1'($urandom_range(0, 1)));
                1:       send(W'($urandom), 8'h00, 1'b1);
                default: send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            endcase
        end
        rand_or = 1'b0;
        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
